data_mem_responder: RTL and testbench

- Memory-side responder for the multi-cycle control FSM's data-memory strobes (MemEn/MemWen), serving LOAD/STORE data accesses.
- Latches one request at a time and services it from an internal word-addressed RAM after a programmable number of wait states.
- Signals completion with a one-cycle ready pulse, which lets the control FSM stall in its MEMORY state.
- Flags out-of-range addresses with an error pulse instead of corrupting memory.

---
 rtl/data_mem_if.sv | 16 +
 rtl/data_mem_responder.sv | 75 +++++++
 tb/tb_data_mem_responder.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_if.sv
// data_mem_if: request/response bundle between the control FSM (master) and the data-memory responder (slave).
interface data_mem_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic mem_en;
    logic mem_wen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic mem_ready;
    logic mem_busy;
    logic mem_err;
    modport master(output mem_en, mem_wen, addr, wdata, input rdata, mem_ready, mem_busy, mem_err);
    modport slave(input mem_en, mem_wen, addr, wdata, output rdata, mem_ready, mem_busy, mem_err);
endinterface

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding data-memory responder with programmable wait states and out-of-range error pulse.
module data_mem_responder #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10,
    parameter int DEPTH = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input logic clk,
    input logic reset,
    data_mem_if.slave bus
);
    localparam int IDX_W = DEPTH > 1 ? $clog2(DEPTH) : 1;
    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
    state_t state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q, rdata_q;
    logic wen_q, err_q, accept, access, in_range;
    logic [IDX_W-1:0] idx;
    logic [DATA_W-1:0] ram [DEPTH];
    // DONE also accepts, so a held mem_en restarts on the same edge that leaves DONE
    assign accept = bus.mem_en && state != WAIT;
    assign access = state == WAIT && cnt == 4'd0;
    assign in_range = 64'(addr_q) < 64'(DEPTH);
    assign idx = addr_q[IDX_W-1:0];
    always_comb begin
        state_n = state;
        cnt_n = cnt;
        unique case (state)
            IDLE, DONE: begin
                state_n = accept ? WAIT : IDLE;
                cnt_n = accept ? 4'(WAIT_CYCLES) : 4'd0;
            end
            WAIT: begin
                state_n = cnt == 4'd0 ? DONE : WAIT;
                cnt_n = cnt == 4'd0 ? 4'd0 : cnt - 4'd1;
            end
            default: begin
                state_n = IDLE;
                cnt_n = 4'd0;
            end
        endcase
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt <= 4'd0;
            addr_q <= '0;
            wdata_q <= '0;
            wen_q <= 1'b0;
            err_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            state <= state_n;
            cnt <= cnt_n;
            if (accept) begin
                addr_q <= bus.addr;
                wdata_q <= bus.wdata;
                wen_q <= bus.mem_wen;
            end
            if (access) begin
                err_q <= !in_range;
                if (!wen_q) rdata_q <= in_range ? ram[idx] : '0;
            end
        end
    end
    // RAM has no reset; an abort in WAIT never reaches the access edge
    always_ff @(posedge clk) begin
        if (access && wen_q && in_range) ram[idx] <= wdata_q;
    end
    assign bus.rdata = rdata_q;
    assign bus.mem_ready = state == DONE;
    assign bus.mem_busy = state != IDLE;
    assign bus.mem_err = state == DONE && err_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized and directed checks of data_mem_responder against a transaction-level memory model.
module tb_data_mem_responder;
    localparam int DW = 32;
    localparam int AW = 11;
    localparam int AWB = 10;
    localparam int DEP = 1024;
    localparam int WC = 2;
    localparam int LAT_A = WC + 1;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int errors = 0;
    int checks = 0;
    logic [DW-1:0] ref_mem [int];
    logic [DW-1:0] ref_rd = '0;
    bit ref_rd_known = 1'b1;
    always #5 clk = ~clk;
    data_mem_if #(.ADDR_W(AW), .DATA_W(DW)) a();
    data_mem_if #(.ADDR_W(AWB), .DATA_W(DW)) b();
    data_mem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .WAIT_CYCLES(WC)) dut_a (
        .clk(clk), .reset(reset), .bus(a.slave));
    data_mem_responder #(.DATA_W(DW), .ADDR_W(AWB), .DEPTH(DEP), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset), .bus(b.slave));

    // Reference: a flat memory plus the last completed-read value
    task automatic model_access(input bit wen, input int ad, input logic [DW-1:0] wd,
                                output bit e_err, output logic [DW-1:0] e_rd, output bit e_known);
        e_err = ad >= DEP;
        if (wen && !e_err) ref_mem[ad] = wd;
        if (!wen) begin
            ref_rd_known = e_err || ref_mem.exists(ad);
            ref_rd = (!e_err && ref_mem.exists(ad)) ? ref_mem[ad] : '0;
        end
        e_rd = ref_rd;
        e_known = ref_rd_known;
    endtask

    // One request on dut_a; observes latency, pulse count, completion data and busy/err shape
    task automatic xact(input bit wen, input int ad, input logic [DW-1:0] wd, input int inj,
                        output int lat, output int pulses, output logic [DW-1:0] rd,
                        output logic er, output int bad);
        @(negedge clk);
        a.mem_en = 1'b1; a.mem_wen = wen; a.addr = AW'(ad); a.wdata = wd;
        @(posedge clk);
        @(negedge clk);
        a.mem_en = 1'b0; a.mem_wen = 1'($urandom); a.addr = AW'($urandom); a.wdata = $urandom;
        lat = -1; pulses = 0; rd = '0; er = 1'b0; bad = 0;
        for (int k = 0; k < WC + 6; k++) begin
            if (a.mem_ready === 1'b1) begin
                pulses++;
                if (lat < 0) begin lat = k; rd = a.rdata; er = a.mem_err; end
            end
            if (a.mem_err === 1'b1 && a.mem_ready !== 1'b1) bad++;
            if (a.mem_busy !== ((lat < 0) || (k == lat))) bad++;
            if (k == inj) begin
                a.mem_en = 1'b1; a.mem_wen = 1'b1; a.addr = AW'(7); a.wdata = 32'hBAD0BAD0;
            end else if (k == inj + 1) a.mem_en = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        a.mem_en = 1'b0; a.mem_wen = 1'b0; a.addr = '0; a.wdata = '0;
        b.mem_en = 1'b0; b.mem_wen = 1'b0; b.addr = '0; b.wdata = '0;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({a.mem_ready, a.mem_busy, a.mem_err} !== 3'b000) begin
            errors++; $display("FAIL reset_ctrl: rdy/busy/err=%b expected 000", {a.mem_ready, a.mem_busy, a.mem_err});
        end
        checks++;
        if (a.rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", a.rdata); end
        checks++;
        if ({b.mem_ready, b.mem_busy, b.mem_err, b.rdata} !== '0) begin
            errors++; $display("FAIL reset_b: rdy/busy/err=%b rdata=%h expected all 0", {b.mem_ready, b.mem_busy, b.mem_err}, b.rdata);
        end
        reset = 1'b0;
        ref_rd = '0; ref_rd_known = 1'b1;
    endtask

    task automatic test_write_read();
        int lat, pulses, bad; logic [DW-1:0] rd, e_rd; logic er; bit e_err, e_kn;
        xact(1'b1, 5, 32'hDEADBEEF, -1, lat, pulses, rd, er, bad);
        model_access(1'b1, 5, 32'hDEADBEEF, e_err, e_rd, e_kn);
        checks++;
        if (lat !== LAT_A) begin errors++; $display("FAIL wr5_latency: got %0d expected %0d", lat, LAT_A); end
        checks++;
        if (pulses !== 1 || bad !== 0) begin errors++; $display("FAIL wr5_handshake: pulses=%0d bad=%0d expected 1/0", pulses, bad); end
        checks++;
        if (er !== e_err) begin errors++; $display("FAIL wr5_err: got %b expected %b", er, e_err); end
        xact(1'b0, 5, 32'h0, -1, lat, pulses, rd, er, bad);
        model_access(1'b0, 5, 32'h0, e_err, e_rd, e_kn);
        checks++;
        if (rd !== e_rd || lat !== LAT_A) begin errors++; $display("FAIL rd5: got %h lat %0d expected %h lat %0d", rd, lat, e_rd, LAT_A); end
    endtask

    task automatic test_boundary();
        int lat, pulses, bad; logic [DW-1:0] rd, e_rd; logic er; bit e_err, e_kn;
        xact(1'b1, 0, 32'h0C0C0C0C, -1, lat, pulses, rd, er, bad);
        model_access(1'b1, 0, 32'h0C0C0C0C, e_err, e_rd, e_kn);
        xact(1'b1, DEP - 1, 32'hA5A5A5A5, -1, lat, pulses, rd, er, bad);
        model_access(1'b1, DEP - 1, 32'hA5A5A5A5, e_err, e_rd, e_kn);
        checks++;
        if (er !== 1'b0) begin errors++; $display("FAIL wr_top_err: got %b expected 0", er); end
        xact(1'b0, DEP - 1, 32'h0, -1, lat, pulses, rd, er, bad);
        model_access(1'b0, DEP - 1, 32'h0, e_err, e_rd, e_kn);
        checks++;
        if (rd !== e_rd || er !== e_err) begin errors++; $display("FAIL rd_top: got %h err %b expected %h err %b", rd, er, e_rd, e_err); end
        xact(1'b1, DEP, 32'hFFFF0000, -1, lat, pulses, rd, er, bad);
        model_access(1'b1, DEP, 32'hFFFF0000, e_err, e_rd, e_kn);
        checks++;
        if (er !== e_err || lat !== LAT_A || pulses !== 1 || bad !== 0) begin
            errors++; $display("FAIL wr_oor: err=%b lat=%0d pulses=%0d bad=%0d expected err=%b lat=%0d 1 pulse", er, lat, pulses, bad, e_err, LAT_A);
        end
        checks++;
        if (rd !== e_rd) begin errors++; $display("FAIL wr_oor_rdata_held: got %h expected %h", rd, e_rd); end
        foreach (ref_mem[i]) begin
            if (i == 0 || i == DEP - 1) begin
                xact(1'b0, i, 32'h0, -1, lat, pulses, rd, er, bad);
                model_access(1'b0, i, 32'h0, e_err, e_rd, e_kn);
                checks++;
                if (rd !== e_rd) begin errors++; $display("FAIL ram_after_oor[%0d]: got %h expected %h", i, rd, e_rd); end
            end
        end
        xact(1'b0, DEP, 32'h0, -1, lat, pulses, rd, er, bad);
        model_access(1'b0, DEP, 32'h0, e_err, e_rd, e_kn);
        checks++;
        if (rd !== e_rd || er !== e_err) begin errors++; $display("FAIL rd_oor: got %h err %b expected %h err %b", rd, er, e_rd, e_err); end
    endtask

    task automatic test_drop();
        int lat, pulses, bad; logic [DW-1:0] rd, e_rd; logic er; bit e_err, e_kn;
        xact(1'b1, 7, 32'h00000077, -1, lat, pulses, rd, er, bad);
        model_access(1'b1, 7, 32'h00000077, e_err, e_rd, e_kn);
        xact(1'b0, 5, 32'h0, 1, lat, pulses, rd, er, bad);
        model_access(1'b0, 5, 32'h0, e_err, e_rd, e_kn);
        checks++;
        if (pulses !== 1 || bad !== 0 || rd !== e_rd) begin
            errors++; $display("FAIL drop_busy: pulses=%0d bad=%0d rd=%h expected 1/0/%h", pulses, bad, rd, e_rd);
        end
        xact(1'b0, 7, 32'h0, -1, lat, pulses, rd, er, bad);
        model_access(1'b0, 7, 32'h0, e_err, e_rd, e_kn);
        checks++;
        if (rd !== e_rd) begin errors++; $display("FAIL drop_addr7: got %h expected %h", rd, e_rd); end
    endtask

    task automatic test_abort();
        int lat, pulses, bad; logic [DW-1:0] rd, e_rd; logic er; bit e_err, e_kn;
        xact(1'b1, 9, 32'h00000099, -1, lat, pulses, rd, er, bad);
        model_access(1'b1, 9, 32'h00000099, e_err, e_rd, e_kn);
        @(negedge clk);
        a.mem_en = 1'b1; a.mem_wen = 1'b1; a.addr = AW'(9); a.wdata = 32'h00001234;
        @(negedge clk);
        a.mem_en = 1'b0;
        checks++;
        if (a.mem_busy !== 1'b1) begin errors++; $display("FAIL abort_accept: busy=%b expected 1", a.mem_busy); end
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({a.mem_ready, a.mem_busy, a.mem_err, a.rdata} !== '0) begin
            errors++; $display("FAIL abort_outputs: rdy/busy/err=%b rdata=%h expected all 0", {a.mem_ready, a.mem_busy, a.mem_err}, a.rdata);
        end
        @(negedge clk);
        reset = 1'b0;
        ref_rd = '0; ref_rd_known = 1'b1;
        xact(1'b0, 9, 32'h0, -1, lat, pulses, rd, er, bad);
        model_access(1'b0, 9, 32'h0, e_err, e_rd, e_kn);
        checks++;
        if (rd !== e_rd) begin errors++; $display("FAIL abort_no_commit: got %h expected %h", rd, e_rd); end
    endtask

    task automatic test_reset_en();
        logic [DW-1:0] e_rd; bit e_err, e_kn; int k;
        @(negedge clk);
        reset = 1'b1;
        a.mem_en = 1'b1; a.mem_wen = 1'b0; a.addr = AW'(5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (a.mem_busy !== 1'b0) begin errors++; $display("FAIL reset_hold_busy[%0d]: got %b expected 0", i, a.mem_busy); end
        end
        reset = 1'b0;
        ref_rd = '0; ref_rd_known = 1'b1;
        @(negedge clk);
        a.mem_en = 1'b0;
        checks++;
        if (a.mem_busy !== 1'b1) begin errors++; $display("FAIL reset_first_accept: busy=%b expected 1", a.mem_busy); end
        model_access(1'b0, 5, 32'h0, e_err, e_rd, e_kn);
        k = 0;
        while (a.mem_ready !== 1'b1 && k < 10) begin @(negedge clk); k++; end
        checks++;
        if (k !== LAT_A || a.rdata !== e_rd) begin
            errors++; $display("FAIL reset_first_read: lat=%0d rd=%h expected lat=%0d rd=%h", k, a.rdata, LAT_A, e_rd);
        end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        b.mem_en = 1'b1; b.mem_wen = 1'b1; b.addr = AWB'(1); b.wdata = 32'h00000011;
        @(negedge clk);
        checks++;
        if ({b.mem_busy, b.mem_ready} !== 2'b10) begin errors++; $display("FAIL b2b_e0: busy/rdy=%b expected 10", {b.mem_busy, b.mem_ready}); end
        @(negedge clk);
        checks++;
        if ({b.mem_ready, b.mem_err} !== 2'b10) begin errors++; $display("FAIL b2b_wr_done: rdy/err=%b expected 10", {b.mem_ready, b.mem_err}); end
        b.mem_wen = 1'b0; b.wdata = $urandom;
        @(negedge clk);
        checks++;
        if ({b.mem_busy, b.mem_ready} !== 2'b10) begin errors++; $display("FAIL b2b_e2_accept: busy/rdy=%b expected 10", {b.mem_busy, b.mem_ready}); end
        b.mem_en = 1'b0;
        @(negedge clk);
        checks++;
        if (b.mem_ready !== 1'b1 || b.rdata !== 32'h00000011) begin
            errors++; $display("FAIL b2b_rd: rdy=%b rd=%h expected 1 00000011", b.mem_ready, b.rdata);
        end
        @(negedge clk);
        checks++;
        if ({b.mem_busy, b.mem_ready} !== 2'b00) begin errors++; $display("FAIL b2b_idle: busy/rdy=%b expected 00", {b.mem_busy, b.mem_ready}); end
    endtask

    task automatic test_random();
        int lat, pulses, bad, ad; logic [DW-1:0] rd, e_rd, wd; logic er; bit e_err, e_kn, wen;
        for (int n = 0; n < 40; n++) begin
            ad = ($urandom % 4 == 0) ? 1000 + int'($urandom % 48) : int'($urandom % 16);
            wen = 1'($urandom);
            wd = $urandom;
            xact(wen, ad, wd, -1, lat, pulses, rd, er, bad);
            model_access(wen, ad, wd, e_err, e_rd, e_kn);
            checks++;
            if (lat !== LAT_A || pulses !== 1 || bad !== 0 || er !== e_err) begin
                errors++; $display("FAIL rand[%0d] ctrl: lat=%0d pulses=%0d bad=%0d err=%b expected lat=%0d 1 pulse err=%b", n, lat, pulses, bad, er, LAT_A, e_err);
            end
            if (e_kn) begin
                checks++;
                if (rd !== e_rd) begin errors++; $display("FAIL rand[%0d] rdata: wen=%b addr=%0d got %h expected %h", n, wen, ad, rd, e_rd); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_boundary();
        test_drop();
        test_abort();
        test_reset_en();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
